module_serial_subtractor: RTL

//  Bit-serial (LSB-first) ripple-borrow subtractor computing D = A - B over ANCHO clock cycles.

---
 rtl/module_serial_subtractor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/module_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : module_serial_subtractor
//  Description : Bit-serial, LSB-first ripple-borrow subtractor that produces
//                D = A - B over ANCHO shift cycles. It uses a valid/ready
//                handshake on the operand side and on the result side.
//                Optional feature macro: OVERFLOW_EN adds the OVF output,
//                which flags signed ANCHO-bit overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module module_serial_subtractor #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ANCHO-1:0] A,
    input  logic [ANCHO-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANCHO:0]   D
`ifdef OVERFLOW_EN
    ,
    output logic             OVF
`endif
);

    localparam int                 c_CNT_W    = $clog2(ANCHO + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ANCHO);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ANCHO-1:0]   r_a_sh;
    logic [ANCHO-1:0]   r_b_sh;
    logic [ANCHO-1:0]   r_result;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ANCHO:0]     r_d;

    logic w_accept;
    logic w_done;
    logic w_release;
    logic w_a0;
    logic w_b0;
    logic w_diff;
    logic w_borrow_nxt;

`ifdef OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;
`endif

    // The operand side is open only in IDLE. It is also held closed while
    // reset is asserted, so no operand can be taken during reset.
    assign in_ready  = (r_state == c_IDLE) && !rst;
    assign out_valid = (r_state == c_HOLD);
    assign D         = r_d;

    assign w_accept  = in_valid && in_ready;
    // After ANCHO shifts the counter sits at ANCHO. That extra cycle copies
    // the finished difference into the output register.
    assign w_done    = (r_state == c_SHIFT) && (r_cnt == c_CNT_LAST);
    assign w_release = (r_state == c_HOLD) && out_ready;

    // Full-subtractor slice that acts on the current LSBs of the shifters.
    assign w_a0         = r_a_sh[0];
    assign w_b0         = r_b_sh[0];
    assign w_diff       = w_a0 ^ w_b0 ^ r_borrow;
    assign w_borrow_nxt = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> SHIFT on accept, SHIFT -> HOLD once the
    // counter is exhausted, HOLD -> IDLE when the consumer takes D.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (w_done) begin
                    w_state_nxt = c_HOLD;
                end
            end
            c_HOLD: begin
                if (w_release) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, run one bit per SHIFT cycle,
    // and load D once at completion. D is cleared only on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_result <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
        end else if (w_accept) begin
            r_a_sh   <= A;
            r_b_sh   <= B;
            r_result <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
        end else if (r_state == c_SHIFT) begin
            if (w_done) begin
                r_d <= {r_borrow, r_result};
            end else begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_result <= {w_diff, r_result[ANCHO-1:1]};
                r_borrow <= w_borrow_nxt;
                r_cnt    <= r_cnt + c_CNT_ONE;
            end
        end
    end

`ifdef OVERFLOW_EN
    // Signed overflow flag. It is computed from the operand sign bits that
    // were captured on accept, it is loaded together with D, and it is
    // cleared when the result is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= A[ANCHO-1];
            r_b_msb <= B[ANCHO-1];
            r_ovf   <= 1'b0;
        end else if (w_done) begin
            r_ovf <= (r_a_msb != r_b_msb) && (r_result[ANCHO-1] != r_a_msb);
        end else if (w_release) begin
            r_ovf <= 1'b0;
        end
    end

    assign OVF = r_ovf;
`endif

endmodule
`default_nettype wire
